// File: rtl/int_res_mem_arbiter.sv
// Two-requester round-robin arbiter onto NUM_BANKS intermediate-result banks, single or double width.
// Optional per-requester stall counters are built when INT_RES_ARB_PERF_CNT_EN is defined.
module int_res_mem_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 14336,
  parameter int N_STO      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0]                   req_write,
  input  logic [1:0]                   req_width,
  input  logic [31:0]                  req_addr,
  input  logic [4*N_STO-1:0]           req_wdata,
  output logic [1:0]                   rsp_valid,
  output logic [2*N_STO-1:0]           rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_BANKS-1:0]         bank_en,
  output logic                         bank_we,
  output logic [13:0]                  bank_addr,
  output logic [N_STO-1:0]             bank_wdata,
  input  logic [NUM_BANKS*N_STO-1:0]   bank_rdata,
  output logic [31:0]                  stall_cnt
);

  localparam int DW          = 2 * N_STO;
  localparam int TOTAL_WORDS = NUM_BANKS * BANK_WORDS;

  typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   ptr_q;
  logic                   err_q;
  logic                   id_q, wr_q, dw_q;
  logic [15:0]            addr_q;
  logic [DW-1:0]          wdata_q;
  logic [N_STO-1:0]       hi_q;
  logic [NUM_BANKS-1:0]   prev_en_q;

  logic [1:0]             grant;
  logic                   grant_id;
  logic                   in_acc;
  logic [16:0]            beat_addr;
  logic [16:0]            beat_quot;
  logic [13:0]            beat_off;
  logic                   beat_err;
  logic [N_STO-1:0]       rd_word;

  function automatic logic signed [DW-1:0] sext_word(input logic signed [N_STO-1:0] w);
    logic signed [DW-1:0] r;
    r = w;
    return r;
  endfunction

  // Grant: preferred requester first, the other one only if the preferred is idle
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && rst_n) begin
      if (req_valid[ptr_q])       grant[ptr_q]  = 1'b1;
      else if (req_valid[~ptr_q]) grant[~ptr_q] = 1'b1;
    end
  end

  assign grant_id  = grant[1];
  assign req_ready = grant;

  // Beat decode: the low word of a double access lives at addr+1, possibly in the next bank
  assign in_acc    = (state_q == ACC_HI) || (state_q == ACC_LO);
  assign beat_addr = {1'b0, addr_q} + {16'd0, state_q == ACC_LO};
  assign beat_err  = beat_addr >= 17'(TOTAL_WORDS);
  assign beat_quot = beat_addr / 17'(BANK_WORDS);
  assign beat_off  = 14'(beat_addr % 17'(BANK_WORDS));

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b] = in_acc && !beat_err && (beat_quot == 17'(b));
    end
  end

  assign bank_we    = in_acc && wr_q && !beat_err;
  assign bank_addr  = (in_acc && !beat_err) ? beat_off : 14'd0;
  assign bank_wdata = !bank_we ? '0 :
                      (state_q == ACC_HI && dw_q) ? wdata_q[DW-1:N_STO] : wdata_q[N_STO-1:0];

  // Read word of the previous beat; an out-of-range beat enabled no bank and reads as 0
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (prev_en_q[b]) rd_word |= bank_rdata[b*N_STO +: N_STO];
    end
  end

  assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = (state_q != RESP || wr_q) ? '0 :
                     dw_q ? {hi_q, rd_word} : sext_word(rd_word);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != 2'b00) state_d = ACC_HI;
      ACC_HI:  state_d = dw_q ? ACC_LO : RESP;
      ACC_LO:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant != 2'b00) begin
        ptr_q <= ~grant_id;
        err_q <= 1'b0;
      end else if (in_acc && beat_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Payload and read-data capture; qualified by the state machine, so no reset needed
  always_ff @(posedge clk) begin
    if (grant != 2'b00) begin
      id_q    <= grant_id;
      wr_q    <= req_write[grant_id];
      dw_q    <= req_width[grant_id];
      addr_q  <= grant_id ? req_addr[31:16] : req_addr[15:0];
      wdata_q <= grant_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    end
    prev_en_q <= bank_en;
    if (state_q == ACC_LO) hi_q <= rd_word;
  end

`ifdef INT_RES_ARB_PERF_CNT_EN
  logic [15:0] stall_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q[0] <= 16'd0;
      stall_q[1] <= 16'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && !req_ready[i] && stall_q[i] != 16'hFFFF)
          stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  assign stall_cnt = {stall_q[1], stall_q[0]};
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Scoreboard bench for int_res_mem_arbiter: behavioural bank memories, flat-memory reference model,
// directed boundary cases followed by randomized two-requester traffic.
module tb_int_res_mem_arbiter;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_WORDS = 14336;
  localparam int TOTAL      = NUM_BANKS * BANK_WORDS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, req_width, rsp_valid;
  logic [31:0] req_addr;
  logic [59:0] req_wdata;
  logic [29:0] rsp_rdata;
  logic        rsp_err;
  logic [NUM_BANKS-1:0]    bank_en;
  logic                    bank_we;
  logic [13:0]             bank_addr;
  logic [14:0]             bank_wdata;
  logic [NUM_BANKS*15-1:0] bank_rdata;
  logic [31:0]             stall_cnt;

  logic        tb_valid [2];
  logic        tb_write [2];
  logic        tb_width [2];
  logic [15:0] tb_addr  [2];
  logic [29:0] tb_wdata [2];

  assign req_valid = {tb_valid[1], tb_valid[0]};
  assign req_write = {tb_write[1], tb_write[0]};
  assign req_width = {tb_width[1], tb_width[0]};
  assign req_addr  = {tb_addr[1],  tb_addr[0]};
  assign req_wdata = {tb_wdata[1], tb_wdata[0]};

  int_res_mem_arbiter #(.NUM_BANKS(NUM_BANKS), .BANK_WORDS(BANK_WORDS), .N_STO(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank memories with one-cycle read latency
  logic        mem_clr;
  logic [14:0] mem [NUM_BANKS][BANK_WORDS];
  logic [14:0] rd  [NUM_BANKS];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int w = 0; w < BANK_WORDS; w++) mem[b][w] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_en[b]) begin
          if (bank_we) mem[b][bank_addr] <= bank_wdata;
          rd[b] <= mem[b][bank_addr];
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_rd
    assign bank_rdata[b*15 +: 15] = rd[b];
  end

  typedef struct {
    int          id;
    logic [29:0] rdata;
    bit          err;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          order_q [$];
  logic [14:0] ref_mem [TOTAL];
  int          stall_model [2];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: memory is a flat array of words; a request touches addr (and addr+1 if double)
  function automatic void model_push(input int id, input bit wr, input bit dw,
                                     input logic [15:0] a, input logic [29:0] d, input int acc);
    exp_t        e;
    logic [14:0] w [2];
    e.err = 0;
    w[0] = '0;
    w[1] = '0;
    for (int k = 0; k < (dw ? 2 : 1); k++) begin
      int ba;
      ba = int'(a) + k;
      if (ba >= TOTAL) begin
        e.err = 1;
      end else begin
        if (wr) ref_mem[ba] = (dw && k == 0) ? d[29:15] : d[14:0];
        w[k] = ref_mem[ba];
      end
    end
    e.id    = id;
    e.rdata = wr ? 30'd0 : (dw ? {w[0], w[1]} : {{15{w[0][14]}}, w[0]});
    e.due   = acc + (dw ? 3 : 2);
    sb.push_back(e);
  endfunction

  task automatic issue(input int id, input bit wr, input bit dw, input logic [15:0] a,
                       input logic [29:0] d, input bit expect_rsp);
    int raise;
    bit done;
    tb_valid[id] = 1'b1;
    tb_write[id] = wr;
    tb_width[id] = dw;
    tb_addr[id]  = a;
    tb_wdata[id] = d;
    raise = cyc;
    done  = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        done = 1;
        order_q.push_back(id);
        stall_model[id] += cyc - raise;
        if (stall_model[id] > 16'hFFFF) stall_model[id] = 16'hFFFF;
        if (expect_rsp) model_push(id, wr, dw, a, d, cyc);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout req%0d actual=no_ready required=ready", id);
    end
    @(posedge clk);
    #1;
    tb_valid[id] = 1'b0;
  endtask

  task automatic chk_beat(input string name, input logic [3:0] en, input logic [13:0] ad,
                          input logic we, input logic [14:0] wd);
    chk({name, "_en"}, 128'(bank_en), 128'(en));
    if (en != 4'd0) chk({name, "_addr"}, 128'(bank_addr), 128'(ad));
    chk({name, "_we"}, 128'(bank_we), 128'(we));
    if (we) chk({name, "_wdata"}, 128'(bank_wdata), 128'(wd));
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_bank"}, 128'({bank_en, bank_we, bank_addr, bank_wdata}), 128'd0);
    chk({name, "_rsp"},  128'({rsp_valid, rsp_rdata, rsp_err, req_ready}), 128'd0);
    chk({name, "_stall"}, 128'(stall_cnt), 128'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 15));
      1:       return 16'(14330 + $urandom_range(0, 10));
      2:       return 16'(28668 + $urandom_range(0, 8));
      3:       return 16'(57335 + $urandom_range(0, 15));
      4:       return 16'(65530 + $urandom_range(0, 5));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%b required=none", rsp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",    128'(rsp_valid), 128'(e.id == 1 ? 2'b10 : 2'b01));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        chk("rsp_err",   128'(rsp_err),   128'(e.err));
        chk("rsp_cycle", 128'(cyc),       128'(e.due));
      end
    end
  end

  initial begin
    for (int i = 0; i < TOTAL; i++) ref_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      tb_valid[i] = 0; tb_write[i] = 0; tb_width[i] = 0; tb_addr[i] = '0; tb_wdata[i] = '0;
      stall_model[i] = 0;
    end
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");
    @(posedge clk);
    #1;

    // Single write then sign-extended single read at the first word of bank 1
    issue(0, 1, 0, 16'd14336, 30'h0000_7FFF, 1);
    @(negedge clk);
    chk_beat("sw_hi", 4'b0010, 14'd0, 1'b1, 15'h7FFF);
    @(posedge clk); #1;
    issue(0, 0, 0, 16'd14336, 30'd0, 1);
    @(negedge clk);
    chk_beat("sr_hi", 4'b0010, 14'd0, 1'b0, 15'd0);
    @(negedge clk);
    chk("sr_resp_data", 128'(rsp_rdata), 128'(30'h3FFF_FFFF));
    @(posedge clk); #1;

    // Double read fully above the top of memory
    issue(0, 0, 1, 16'd57344, 30'd0, 1);
    @(negedge clk);
    chk_beat("oor_hi", 4'b0000, 14'd0, 1'b0, 15'd0);
    @(negedge clk);
    chk_beat("oor_lo", 4'b0000, 14'd0, 1'b0, 15'd0);
    @(posedge clk); #1;

    // Double write straddling banks 0 and 1, then read it back
    issue(1, 1, 1, 16'd14335, 30'h2AAA_5555, 1);
    @(negedge clk);
    chk_beat("dw_hi", 4'b0001, 14'd14335, 1'b1, 15'h5554);
    @(negedge clk);
    chk_beat("dw_lo", 4'b0010, 14'd0, 1'b1, 15'h5555);
    @(posedge clk); #1;
    issue(1, 0, 1, 16'd14335, 30'd0, 1);
    repeat (4) @(posedge clk);
    #1;

    // Both requesters continuously valid: grants alternate
    order_q.delete();
    fork
      begin issue(0, 0, 0, 16'd10, 30'd0, 1); issue(0, 0, 0, 16'd30, 30'd0, 1); end
      begin issue(1, 0, 0, 16'd20, 30'd0, 1); issue(1, 0, 0, 16'd40, 30'd0, 1); end
    join
    chk("rr_count", 128'(order_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      chk("rr_order", 128'(order_q[i]), 128'(i % 2));
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a double read: abandoned, no response
    issue(0, 0, 1, 16'd100, 30'd0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall_model[0] = 0;
    stall_model[1] = 0;
    #1;
    chk_quiet("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1, 1, 16'd28671, 30'h1234_5678, 1);
    issue(0, 0, 1, 16'd28671, 30'd0, 1);

    // Randomized traffic from both requesters
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(0, ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), rand_addr(),
                30'($urandom), 1);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(1, ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), rand_addr(),
                30'($urandom), 1);
        end
      end
    join

    for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
    chk("sb_drain", 128'(sb.size()), 128'd0);
`ifdef INT_RES_ARB_PERF_CNT_EN
    chk("stall_cnt0", 128'(stall_cnt[15:0]),  128'(stall_model[0]));
    chk("stall_cnt1", 128'(stall_cnt[31:16]), 128'(stall_model[1]));
`else
    chk("stall_cnt", 128'(stall_cnt), 128'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_res_mem_arbiter.md
INT_RES_MEM_ARBITER -- requirements
Module: int_res_mem_arbiter

Interface
REQ-001 SHALL have parameters: NUM_BANKS, default 4, number of intermediate-result banks; BANK_WORDS, default 14336, words per bank; N_STO, default 15, stored word width.
REQ-002 SHALL have ports (IntResAddr_t 16b, bank address 14b):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  2  request per requester
- req_ready  out  2  grant/accept
- req_write  in  2  1=write
- req_width  in  2  DataWidth_t per requester
- req_addr  in  2x16  word address
- req_wdata  in  2x30  write data; single-width uses [14:0]
- rsp_valid  out  2  one-cycle completion pulse
- rsp_rdata  out  30  read data
- rsp_err  out  1  out-of-range flag, valid with rsp_valid
- bank_en  out  NUM_BANKS  one-hot bank select
- bank_we  out  1  write enable
- bank_addr  out  14  in-bank address
- bank_wdata  out  15  bank write word
- bank_rdata  in  NUM_BANKSx15  bank read words, 1-cycle latency
- stall_cnt  out  2x16  per-requester stall counters
REQ-003 SHALL be clocked on clk only; SHALL reset asynchronously when rst_n is low.

Function
REQ-004 SHALL implement FSM IDLE -> ACC_HI -> (ACC_LO if DOUBLE_WIDTH) -> RESP -> IDLE.
REQ-005 In IDLE, SHALL assert req_ready combinationally to exactly one valid requester, chosen round-robin; SHALL assert no ready in other states.
REQ-006 Round-robin pointer SHALL move to the other requester after each grant; with both valid, grants SHALL alternate.
REQ-007 On accept (valid&ready), SHALL latch requester id, write, width, addr, wdata.
REQ-008 In ACC_HI, SHALL target addr; in ACC_LO, addr+1; each beat decoded separately: bank=a/BANK_WORDS, bank_addr=a%BANK_WORDS.
REQ-009 Double-width SHALL write wdata[29:15] in ACC_HI and wdata[14:0] in ACC_LO; single-width SHALL write wdata[14:0] in ACC_HI.
REQ-010 In ACC_LO, SHALL capture the ACC_HI bank_rdata as high word.
REQ-011 In RESP, SHALL pulse rsp_valid[id] one cycle; rsp_rdata SHALL be {high, low bank_rdata} for double, sign-extended 15b bank_rdata for single, 0 for writes.
REQ-012 Latency SHALL be: accept in cycle N, rsp_valid in N+2 (single) or N+3 (double); new grant earliest in RESP+1.
REQ-013 Beat address >= NUM_BANKS*BANK_WORDS SHALL assert no bank_en, drop the write, return 0 for that word, and set rsp_err in RESP.
REQ-014 Double-width at a bank's last word SHALL cross to the next bank's word 0; no address wrap at top of memory (error per REQ-013).
REQ-015 bank_en SHALL be all-zero outside ACC_HI/ACC_LO; bank_we SHALL be 0 for reads.
REQ-016 Requesters SHALL hold valid and payload stable until ready; a drop before ready SHALL be ignored.

Reset
REQ-017 Reset SHALL force IDLE, pointer to requester 0, all outputs 0, stall_cnt 0.
REQ-018 Reset mid-transaction SHALL abandon it with no rsp_valid; a partial double write MAY leave the high word written.

Configuration
REQ-019 With INT_RES_ARB_PERF_CNT_EN defined, stall_cnt[i] SHALL increment (saturating at 0xFFFF) each cycle req_valid[i] & !req_ready[i]; undefined, stall_cnt SHALL be constant 0 with no counter logic.

Verification
REQ-020 Single read req0 addr 14336, bank_rdata[1]=0x7FFF -> bank_en=0b0010, bank_addr=0, rsp_valid[0] at N+2, rsp_rdata=0x3FFF_FFFF (sign-extended -1).
REQ-021 Double write req1 addr 14335, wdata=0x2AAA_5555 -> ACC_HI bank0 addr 14335 data 0x5554; ACC_LO bank1 addr 0 data 0x5555; rsp_valid[1] at N+3.
REQ-022 Both valid continuously for 4 grants -> order 0,1,0,1; stall_cnt with macro = 3 per completed transaction of the other requester.
REQ-023 Read addr 57344 -> bank_en=0 both cycles, rsp_rdata=0, rsp_err=1.
REQ-024 rst_n low during ACC_LO -> immediate IDLE, no rsp_valid, outputs 0; next request served normally.
